// File: rtl/transposer_row_egress_bridge.sv
// Row egress bridge: a valid-only producer feeds a small circular FIFO that drains
// through a Decoupled consumer port; beats that arrive while the FIFO is full are dropped and counted.
module transposer_row_egress_bridge #(
  parameter int LANES = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_input_0_payload_discriminant,
  input  logic [LANES*8-1:0]   in_input_0_payload_Some_0,
  output logic                 io_outRow_valid,
  output logic [7:0]           io_outRow_bits_0,
  output logic [7:0]           io_outRow_bits_1,
  output logic [7:0]           io_outRow_bits_2,
  output logic [7:0]           io_outRow_bits_3,
  output logic [7:0]           io_outRow_bits_4,
  output logic [7:0]           io_outRow_bits_5,
  output logic [7:0]           io_outRow_bits_6,
  output logic [7:0]           io_outRow_bits_7,
  output logic [7:0]           io_outRow_bits_8,
  output logic [7:0]           io_outRow_bits_9,
  output logic [7:0]           io_outRow_bits_10,
  output logic [7:0]           io_outRow_bits_11,
  output logic [7:0]           io_outRow_bits_12,
  output logic [7:0]           io_outRow_bits_13,
  output logic [7:0]           io_outRow_bits_14,
  output logic [7:0]           io_outRow_bits_15,
  input  logic                 io_outRow_ready,
  output logic                 io_almostFull,
  output logic                 io_overflow,
  output logic [CNT_W-1:0]     io_dropCount,
  input  logic                 io_clearOverflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int OUT_LANES = 16;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] ALMOST_OCC = OCC_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DROP_MAX = '1;

  logic [LANES*8-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       count;
  logic                   pop;
  logic                   push;
  logic                   drop;
  logic [LANES*8-1:0]     head;
  logic [OUT_LANES*8-1:0] head_wide;

  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign pop  = io_outRow_valid & io_outRow_ready;
  assign push = in_input_0_payload_discriminant & ((count != FULL_OCC) | pop);
  assign drop = in_input_0_payload_discriminant & (count == FULL_OCC) & ~pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_input_0_payload_Some_0;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a drop restarts the tally at one rather than zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_overflow  <= 1'b0;
      io_dropCount <= '0;
    end else if (io_clearOverflow) begin
      io_overflow  <= drop;
      io_dropCount <= drop ? CNT_W'(1) : '0;
    end else if (drop) begin
      io_overflow <= 1'b1;
      if (io_dropCount != DROP_MAX) io_dropCount <= io_dropCount + 1'b1;
    end
  end

  assign io_outRow_valid = (count != '0);
  assign io_almostFull   = (count >= ALMOST_OCC);
  assign head            = mem[rd_ptr];

  // Lane ports are fixed at sixteen; lanes the row does not carry read as zero.
  for (genvar k = 0; k < OUT_LANES; k++) begin : g_lane
    if (k < LANES) begin : g_used
      assign head_wide[k*8 +: 8] = head[k*8 +: 8];
    end else begin : g_unused
      assign head_wide[k*8 +: 8] = 8'h00;
    end
  end

  assign io_outRow_bits_0  = head_wide[0*8 +: 8];
  assign io_outRow_bits_1  = head_wide[1*8 +: 8];
  assign io_outRow_bits_2  = head_wide[2*8 +: 8];
  assign io_outRow_bits_3  = head_wide[3*8 +: 8];
  assign io_outRow_bits_4  = head_wide[4*8 +: 8];
  assign io_outRow_bits_5  = head_wide[5*8 +: 8];
  assign io_outRow_bits_6  = head_wide[6*8 +: 8];
  assign io_outRow_bits_7  = head_wide[7*8 +: 8];
  assign io_outRow_bits_8  = head_wide[8*8 +: 8];
  assign io_outRow_bits_9  = head_wide[9*8 +: 8];
  assign io_outRow_bits_10 = head_wide[10*8 +: 8];
  assign io_outRow_bits_11 = head_wide[11*8 +: 8];
  assign io_outRow_bits_12 = head_wide[12*8 +: 8];
  assign io_outRow_bits_13 = head_wide[13*8 +: 8];
  assign io_outRow_bits_14 = head_wide[14*8 +: 8];
  assign io_outRow_bits_15 = head_wide[15*8 +: 8];

endmodule
